// File: rtl/avl_burst.sv
// Avalon-MM master bridge: turns single-word requests into Avalon reads (single or
// fixed-length burst) and writes, returning one response beat per data/response.
module avl_burst #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned BURST = 4,
  localparam int unsigned NB   = XLEN / 8,
  localparam int unsigned BCW  = $clog2(BURST) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [NB-1:0]     req_wstrb,
  input  logic              req_burst,
  output logic              rsp_valid,
  output logic              rsp_last,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_error,
  output logic [31:0]       m_avl_address,
  output logic [NB-1:0]     m_avl_byteenable,
  output logic              m_avl_lock,
  output logic              m_avl_read,
  output logic              m_avl_write,
  output logic [XLEN-1:0]   m_avl_writedata,
  output logic [BCW-1:0]    m_avl_burstcount,
  input  logic [XLEN-1:0]   m_avl_readdata,
  input  logic [1:0]        m_avl_response,
  input  logic              m_avl_waitrequest,
  input  logic              m_avl_readdatavalid,
  input  logic              m_avl_writeresponsevalid
);

  localparam int unsigned SBITS = $clog2(NB);
  localparam int unsigned BBITS = $clog2(BURST * NB);
  localparam logic [31:0] SMASK = ~((32'd1 << SBITS) - 32'd1);
  localparam logic [31:0] BMASK = ~((32'd1 << BBITS) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RCMD,
    S_RDATA,
    S_WCMD,
    S_WRSP
  } state_t;

  state_t           r_state;
  logic [BCW-1:0]   r_beats;
  logic [BCW-1:0]   w_beat_nxt;
  logic             w_beat_last;
  logic             w_rsp_err;

  assign req_ready   = (r_state == S_IDLE);
  assign m_avl_lock  = 1'b0;
  assign w_beat_nxt  = r_beats + BCW'(1);
  // burstcount is held after the command is accepted and doubles as the beat target
  assign w_beat_last = (w_beat_nxt == m_avl_burstcount);
  assign w_rsp_err   = (m_avl_response != 2'b00);

  // Command issue, beat counting and response generation
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_beats          <= '0;
      m_avl_address    <= '0;
      m_avl_byteenable <= '0;
      m_avl_read       <= 1'b0;
      m_avl_write      <= 1'b0;
      m_avl_writedata  <= '0;
      m_avl_burstcount <= '0;
      rsp_valid        <= 1'b0;
      rsp_last         <= 1'b0;
      rsp_rdata        <= '0;
      rsp_error        <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_beats <= '0;
            if (req_wstrb == '0) begin
              r_state          <= S_RCMD;
              m_avl_read       <= 1'b1;
              m_avl_byteenable <= '1;
              m_avl_writedata  <= '0;
              m_avl_address    <= req_addr & (req_burst ? BMASK : SMASK);
              m_avl_burstcount <= req_burst ? BCW'(BURST) : BCW'(1);
            end else begin
              r_state          <= S_WCMD;
              m_avl_write      <= 1'b1;
              m_avl_byteenable <= req_wstrb;
              m_avl_writedata  <= req_wdata;
              m_avl_address    <= req_addr & SMASK;
              m_avl_burstcount <= BCW'(1);
            end
          end
        end

        S_RCMD, S_RDATA: begin
          if ((r_state == S_RCMD) && !m_avl_waitrequest) begin
            r_state          <= S_RDATA;
            m_avl_read       <= 1'b0;
            m_avl_address    <= '0;
            m_avl_byteenable <= '0;
          end
          if (m_avl_readdatavalid) begin
            r_beats   <= w_beat_nxt;
            rsp_valid <= 1'b1;
            rsp_last  <= w_beat_last;
            rsp_rdata <= m_avl_readdata;
            rsp_error <= w_rsp_err;
            if (w_beat_last) begin
              r_state          <= S_IDLE;
              r_beats          <= '0;
              m_avl_read       <= 1'b0;
              m_avl_address    <= '0;
              m_avl_byteenable <= '0;
            end
          end
        end

        S_WCMD: begin
          if (!m_avl_waitrequest) begin
            r_state          <= S_WRSP;
            m_avl_write      <= 1'b0;
            m_avl_address    <= '0;
            m_avl_byteenable <= '0;
            m_avl_writedata  <= '0;
          end
        end

        S_WRSP: begin
          if (m_avl_writeresponsevalid) begin
            r_state   <= S_IDLE;
            rsp_valid <= 1'b1;
            rsp_last  <= 1'b1;
            rsp_error <= w_rsp_err;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/avl_burst.md
AVL_BURST -- requirements
Module: avl_burst

Interface
REQ-001 SHALL provide parameter XLEN, default 32, Avalon data width; legal values 32, 64.
REQ-002 SHALL provide parameter BURST, default 4, beats per burst read; legal values 1, 2, 4, 8.
REQ-003 SHALL derive NB = XLEN/8 (byte lanes) and BCW = clog2(BURST)+1 (burstcount width).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports, in order:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle.
- req_addr  in  32  byte address.
- req_wdata  in  XLEN  write data.
- req_wstrb  in  NB  byte strobes; all zero = read.
- req_burst  in  1  read is BURST beats (ignored for writes).
- rsp_valid  out  1  one response beat.
- rsp_last  out  1  final beat of a transaction.
- rsp_rdata  out  XLEN  read data.
- rsp_error  out  1  beat carried non-OKAY response.
- m_avl_address  out  32
- m_avl_byteenable  out  NB
- m_avl_lock  out  1  tied 0.
- m_avl_read  out  1
- m_avl_write  out  1
- m_avl_writedata  out  XLEN
- m_avl_burstcount  out  BCW
- m_avl_readdata  in  XLEN
- m_avl_response  in  2
- m_avl_waitrequest  in  1
- m_avl_readdatavalid  in  1
- m_avl_writeresponsevalid  in  1

Function
REQ-006 SHALL implement FSM states IDLE, RCMD, RDATA, WCMD, WRSP.
REQ-007 SHALL assert req_ready combinationally iff state is IDLE; handshake = req_valid & req_ready.
REQ-008 On read handshake SHALL go to RCMD, register address, byteenable all ones, burstcount = BURST if req_burst else 1.
REQ-009 For burst reads SHALL force address bits [clog2(BURST*NB)-1:0] to zero; single reads force bits [clog2(NB)-1:0] to zero.
REQ-010 On write handshake SHALL go to WCMD, register word-aligned address, req_wstrb, req_wdata, burstcount 1.
REQ-011 All m_avl_* outputs SHALL be registered; m_avl_read/m_avl_write assert the cycle after handshake.
REQ-012 In RCMD/WCMD, command outputs SHALL hold stable while m_avl_waitrequest = 1.
REQ-013 Command accepted when waitrequest = 0 with read/write high; next edge deasserts read/write, zeroes address/data/byteenable, moves RCMD->RDATA, WCMD->WRSP.
REQ-014 SHALL count read beats with m_avl_readdatavalid in RCMD or RDATA; counter width BCW.
REQ-015 Per read beat SHALL, next cycle, assert rsp_valid with rsp_rdata = m_avl_readdata, rsp_error = (m_avl_response != 0).
REQ-016 rsp_last SHALL assert with the beat whose count equals burstcount; FSM returns to IDLE on that edge.
REQ-017 In WRSP, m_avl_writeresponsevalid SHALL, next cycle, give rsp_valid = rsp_last = 1, rsp_rdata = 0, rsp_error = (m_avl_response != 0); FSM to IDLE.
REQ-018 rsp_* SHALL be zero in every cycle without a response beat.
REQ-019 readdatavalid/writeresponsevalid in IDLE, WCMD, or mismatched state SHALL be ignored.
REQ-020 An error beat SHALL NOT truncate a burst; all burstcount beats are returned.
REQ-021 Response beats SHALL have no backpressure; requester always accepts rsp_valid.

Reset
REQ-022 Reset low SHALL asynchronously force IDLE, beat counter 0, all m_avl_* outputs 0, rsp_* 0.
REQ-023 Reset mid-transaction SHALL abandon it without a response; first post-reset cycle has req_ready = 1.

Verification
REQ-024 Single read 0x1004, waitrequest 0, readdatavalid 2 cycles later with 0xDEADBEEF -> one read pulse, burstcount 1, rsp_valid=rsp_last=1, rdata 0xDEADBEEF, error 0.
REQ-025 Burst read 0x100C, BURST 4, XLEN 32 -> address 0x1000, burstcount 4, four rsp_valid beats in order, rsp_last on fourth only.
REQ-026 Write 0x2002, wstrb 0x3, waitrequest high 3 cycles -> address/data/byteenable stable all 4 cycles, one accepted write, one rsp_valid after writeresponsevalid.
REQ-027 Burst read, beat 2 response 2'b10 -> rsp_error only on beat 2, all four beats delivered.
REQ-028 Reset low during RDATA after beat 1 -> outputs zero immediately, req_ready 1 after release, later beats ignored.
REQ-029 XLEN 64, BURST 8 burst read at 0x1234 -> address 0x1200, burstcount 8, byteenable 0xFF.
